// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer.
// The state enum is also used by anything that observes the FSM.
package rst_seq_pkg;

    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_ACK_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD      = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_RUN       = 3'd4
    } rst_seq_state_t;

    // Index width that stays legal when there is only one stage.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Width-parameterised two-flop synchronizer for bringing asynchronous
// level signals into the local clock domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds every downstream domain in reset until the clock
// source locks, then releases the domains one at a time in index order.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  lock_in,
    input  logic                  soft_rst_req,
    input  logic [NUM_STAGES-1:0] ack_in,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);
    localparam int IDX_W  = idx_width(NUM_STAGES);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    logic                  w_lock_sync;
    logic [NUM_STAGES-1:0] w_ack_sync;

    rst_seq_state_t        r_state,       w_state_next;
    logic [IDX_W-1:0]      r_idx,         w_idx_next;
    logic [HOLD_W-1:0]     r_hold_cnt,    w_hold_next;
    logic [TO_W-1:0]       r_to_cnt,      w_to_next;
    logic [NUM_STAGES-1:0] r_rst_out,     w_rst_next;
    logic                  r_busy,        w_busy_next;
    logic                  r_done,        w_done_next;
    logic                  r_timeout_err, w_terr_next;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_d     (lock_in),
        .o_q     (w_lock_sync)
    );

    sync_2ff #(.WIDTH(NUM_STAGES)) u_ack_sync (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_d     (ack_in),
        .o_q     (w_ack_sync)
    );

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_hold_next  = r_hold_cnt;
        w_to_next    = r_to_cnt;
        w_rst_next   = r_rst_out;
        w_terr_next  = r_timeout_err;

        // Lock loss outranks a soft request arriving in the same cycle.
        if (r_state != ST_WAIT_LOCK && !w_lock_sync) begin
            w_state_next = ST_WAIT_LOCK;
            w_rst_next   = '1;
            w_idx_next   = '0;
            w_hold_next  = '0;
            w_to_next    = '0;
        end else if (r_state != ST_WAIT_LOCK && soft_rst_req) begin
            w_state_next = ST_HOLD;
            w_rst_next   = '1;
            w_idx_next   = '0;
            w_hold_next  = '0;
            w_to_next    = '0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    w_rst_next  = '1;
                    w_idx_next  = '0;
                    w_hold_next = '0;
                    w_to_next   = '0;
                    if (w_lock_sync) begin
                        w_state_next = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    w_rst_next = '1;
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_state_next = ST_RELEASE;
                        w_hold_next  = '0;
                        w_idx_next   = '0;
                    end else begin
                        w_hold_next = r_hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    w_rst_next[r_idx] = 1'b0;
                    w_to_next         = '0;
                    w_state_next      = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // A stuck acknowledge is treated as an acknowledge, but flagged.
                    if (!w_ack_sync[r_idx] || r_to_cnt == TO_LAST) begin
                        if (w_ack_sync[r_idx]) begin
                            w_terr_next = 1'b1;
                        end
                        w_to_next = '0;
                        if (r_idx == IDX_LAST) begin
                            w_state_next = ST_RUN;
                        end else begin
                            w_idx_next   = r_idx + 1'b1;
                            w_state_next = ST_RELEASE;
                        end
                    end else begin
                        w_to_next = r_to_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    w_rst_next = '0;
                end
                default: begin
                    w_state_next = ST_WAIT_LOCK;
                    w_rst_next   = '1;
                end
            endcase
        end

        w_busy_next = (w_state_next != ST_RUN);
        w_done_next = (w_state_next == ST_RUN);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= ST_WAIT_LOCK;
            r_idx         <= '0;
            r_hold_cnt    <= '0;
            r_to_cnt      <= '0;
            r_rst_out     <= '1;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_hold_cnt    <= w_hold_next;
            r_to_cnt      <= w_to_next;
            r_rst_out     <= w_rst_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_timeout_err <= w_terr_next;
        end
    end

    assign rst_out     = r_rst_out;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of downstream reset domains, released in index order 0..NUM_STAGES-1.
REQ-002 Parameter HOLD_CYCLES, default 16: minimum cycles all resets are held asserted before sequencing.
REQ-003 Parameter ACK_TIMEOUT, default 1024: maximum cycles to wait for one stage's acknowledge.
REQ-004 clk_in  input  1  sole clock; all logic on posedge clk_in.
REQ-005 rst_n_in  input  1  asynchronous, active-low reset.
REQ-006 lock_in  input  1  clock-source lock, asynchronous to clk_in.
REQ-007 soft_rst_req  input  1  single-cycle synchronous request for a full re-sequence.
REQ-008 ack_in  input  NUM_STAGES  per-domain "still in reset" feedback (the domain's synchronised reset), asynchronous to clk_in.
REQ-009 rst_out  output  NUM_STAGES  active-high reset to each domain.
REQ-010 busy  output  1  high while sequencing is in progress.
REQ-011 done  output  1  high only in RUN.
REQ-012 timeout_err  output  1  sticky; set when any stage acknowledge times out.

Function
REQ-013 lock_in and ack_in shall each pass through a 2-flop synchronizer before use, adding 2 cycles of latency.
REQ-014 States: WAIT_LOCK, HOLD, RELEASE, WAIT_ACK, RUN.
REQ-015 WAIT_LOCK: all rst_out=1, busy=1, done=0; go to HOLD when synchronised lock is 1.
REQ-016 HOLD: all rst_out=1; the hold counter counts HOLD_CYCLES cycles, then go to RELEASE with stage index 0.
REQ-017 RELEASE: clear rst_out[idx] on the following clock edge, clear the timeout counter, then go to WAIT_ACK.
REQ-018 WAIT_ACK: when synchronised ack_in[idx]=0, advance idx and go to RELEASE; if idx is the last stage, go to RUN instead.
REQ-019 WAIT_ACK timeout: after ACK_TIMEOUT cycles without acknowledge, set timeout_err and advance exactly as for an acknowledge.
REQ-020 Once released, rst_out bits shall stay 0 until a re-sequence, so already-released stages are never re-asserted individually.
REQ-021 RUN: all rst_out=0, busy=0, done=1.
REQ-022 Loss of lock: synchronised lock=0 in any state other than WAIT_LOCK shall set all rst_out=1 on the next edge and go to WAIT_LOCK.
REQ-023 soft_rst_req=1 in HOLD, RELEASE, WAIT_ACK or RUN shall set all rst_out=1 on the next edge and restart HOLD with the hold counter cleared.
REQ-024 soft_rst_req shall be ignored in WAIT_LOCK.
REQ-025 If lock loss and soft_rst_req occur in the same cycle, lock loss wins.
REQ-026 timeout_err shall be cleared only by rst_n_in, never by a soft reset or lock loss.
REQ-027 All outputs shall be driven directly from flops, with no combinational paths from input to output.
REQ-028 Counter widths: hold counter $clog2(HOLD_CYCLES+1) bits; timeout counter $clog2(ACK_TIMEOUT+1) bits; neither counter shall wrap.

Reset
REQ-029 While rst_n_in=0 (asynchronous assertion), the block shall be in state WAIT_LOCK with rst_out all ones, busy=1, done=0, timeout_err=0, all counters 0, idx 0 and all synchronizer flops 0.
REQ-030 Release of rst_n_in shall take effect on the next clk_in edge; the block cannot leave WAIT_LOCK earlier than 2 cycles after release because of the lock synchronizer.

Structure
REQ-031 Package rst_seq_pkg shall hold the state enum rst_seq_state_t and the default values for HOLD_CYCLES and ACK_TIMEOUT.
REQ-032 Sub-module sync_2ff shall be a width-parameterised 2-flop synchronizer with asynchronous active-low reset, instantiated once for lock_in and once for ack_in.

Verification
REQ-033 Power-up: NUM_STAGES=3, HOLD_CYCLES=4, lock_in=1 and ack_in mirroring rst_out -> rst_out steps 111->110->100->000, done=1, timeout_err=0.
REQ-034 Stuck acknowledge: ack_in[1] held at 1 with ACK_TIMEOUT=8 -> stage 2 released 8 cycles after stage 1 enters WAIT_ACK, timeout_err=1, done=1.
REQ-035 Lock loss in RUN: lock_in drops -> rst_out=111 within 3 cycles and the FSM is in WAIT_LOCK; full re-sequence follows when lock returns.
REQ-036 Soft reset mid-sequence: soft_rst_req pulsed in WAIT_ACK for stage 1 -> rst_out=111 on the next edge and the 4-cycle hold restarts.
REQ-037 Simultaneous events: lock loss and soft_rst_req in the same cycle -> FSM goes to WAIT_LOCK, not HOLD.
REQ-038 Asynchronous reset mid-operation: rst_n_in asserted between clock edges -> rst_out=111 and timeout_err=0 without waiting for a clock edge.
